// File: rtl/dct_transpose_buf.sv
// -----------------------------------------------------------------------------
// dct_transpose_buf
//
// Ping-pong 8x8 transpose buffer sitting between the row-pass and the
// column-pass 1-D DCT. Rows of a block are written one per handshake; once
// the eighth row lands, the block is presented column by column. Two banks
// let the next block be written while the previous one is being read.
//
// Ports
//   clk                 single clock, all state updates on rising edge
//   rst                 synchronous, active-high reset
//   in_valid / in_ready row handshake (in_ready depends only on state)
//   in0..in7            row coefficients, inK = column K of the row
//   out_valid/out_ready column handshake
//   out0..out7          column coefficients, outK = row K of the column
//   out_col             index of the column being presented
//   out_last            marks column 7 of a block
//
// Data outputs, out_col and out_last are forced to zero whenever out_valid is
// low, so the downstream stage never sees stale bank contents.
// -----------------------------------------------------------------------------
module dct_transpose_buf #(
    parameter int IN_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in0,
    input  logic signed [IN_W-1:0] in1,
    input  logic signed [IN_W-1:0] in2,
    input  logic signed [IN_W-1:0] in3,
    input  logic signed [IN_W-1:0] in4,
    input  logic signed [IN_W-1:0] in5,
    input  logic signed [IN_W-1:0] in6,
    input  logic signed [IN_W-1:0] in7,

    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [IN_W-1:0] out0,
    output logic signed [IN_W-1:0] out1,
    output logic signed [IN_W-1:0] out2,
    output logic signed [IN_W-1:0] out3,
    output logic signed [IN_W-1:0] out4,
    output logic signed [IN_W-1:0] out5,
    output logic signed [IN_W-1:0] out6,
    output logic signed [IN_W-1:0] out7,
    output logic [2:0]             out_col,
    output logic                   out_last
);

    typedef logic signed [IN_W-1:0] coef_t;

    // Storage: [bank][row][col]. Not reset; the full flags decide validity.
    coef_t mem_q [2][8][8];

    logic [1:0] full_q,    full_d;
    logic       wr_bank_q, wr_bank_d;
    logic [2:0] wr_row_q,  wr_row_d;
    logic       rd_bank_q, rd_bank_d;
    logic [2:0] rd_col_q,  rd_col_d;

    coef_t in_vec [8];
    coef_t rd_vec [8];

    logic wr_fire;
    logic rd_fire;

    assign in_vec[0] = in0;
    assign in_vec[1] = in1;
    assign in_vec[2] = in2;
    assign in_vec[3] = in3;
    assign in_vec[4] = in4;
    assign in_vec[5] = in5;
    assign in_vec[6] = in6;
    assign in_vec[7] = in7;

    // Handshake qualifiers: both sides look only at registered state.
    assign in_ready  = ~full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign wr_fire   = in_valid & in_ready;
    assign rd_fire   = out_valid & out_ready;

    // Pointer / flag next-state. A write completion and a read completion in
    // the same cycle always touch different banks (writes only go to an empty
    // bank, reads only come from a full one), so both updates can apply.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_row_d  = wr_row_q;
        rd_bank_d = rd_bank_q;
        rd_col_d  = rd_col_q;

        if (wr_fire) begin
            wr_row_d = wr_row_q + 3'd1;
            if (wr_row_q == 3'd7) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        if (rd_fire) begin
            rd_col_d = rd_col_q + 3'd1;
            if (rd_col_q == 3'd7) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            wr_row_q  <= 3'd0;
            rd_bank_q <= 1'b0;
            rd_col_q  <= 3'd0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_row_q  <= wr_row_d;
            rd_bank_q <= rd_bank_d;
            rd_col_q  <= rd_col_d;
        end
    end

    // Row write into the current write bank. Gated by rst so a write in a
    // reset cycle cannot leave half a row behind.
    always_ff @(posedge clk) begin
        if (wr_fire && !rst) begin
            for (int k = 0; k < 8; k++) begin
                mem_q[wr_bank_q][wr_row_q][k] <= in_vec[k];
            end
        end
    end

    // Column read: element K of the column comes from row K of the bank.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            rd_vec[k] = '0;
            if (out_valid) begin
                rd_vec[k] = mem_q[rd_bank_q][k][rd_col_q];
            end
        end
    end

    assign out0 = rd_vec[0];
    assign out1 = rd_vec[1];
    assign out2 = rd_vec[2];
    assign out3 = rd_vec[3];
    assign out4 = rd_vec[4];
    assign out5 = rd_vec[5];
    assign out6 = rd_vec[6];
    assign out7 = rd_vec[7];

    assign out_col  = out_valid ? rd_col_q : 3'd0;
    assign out_last = out_valid & (rd_col_q == 3'd7);

endmodule

// File: tb/tb_dct_transpose_buf.sv
module tb_dct_transpose_buf;

    localparam int IN_W = 32;
    localparam int VW   = 8 * IN_W;
    typedef logic [VW-1:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [IN_W-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic signed [IN_W-1:0] in4 = '0, in5 = '0, in6 = '0, in7 = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic signed [IN_W-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [2:0] out_col;
    logic out_last;

    always #5 clk = ~clk;

    dct_transpose_buf #(.IN_W(IN_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .in4(in4), .in5(in5), .in6(in6), .in7(in7),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out4(out4), .out5(out5), .out6(out6), .out7(out7),
        .out_col(out_col), .out_last(out_last)
    );

    typedef struct packed {
        logic [2:0] col;
        vec_t       d;
    } col_t;

    col_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_v(input string name, input vec_t act, input vec_t req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic check_i(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Stimulus vectors. kind 0: r*8+K, 1: 1000*blk+r*8+K, 2: negatives,
    // 3: 7*r+K, other: junk that must never reach the output.
    function automatic logic [IN_W-1:0] row_val(input int kind, input int blk,
                                                input int r, input int k);
        int v;
        case (kind)
            0:       v = r * 8 + k;
            1:       v = 1000 * blk + r * 8 + k;
            2:       v = (k == 0) ? -32768 : (k == 7) ? -1 : -(100 * blk + r * 8 + k + 1);
            3:       v = 7 * r + k;
            default: v = 32'h5A00 + r * 8 + k;
        endcase
        return v;
    endfunction

    // Expected column c: element K is row K, column c of the written block.
    task automatic push_exp(input int kind, input int blk);
        col_t e;
        for (int c = 0; c < 8; c++) begin
            e.col = 3'(c);
            for (int k = 0; k < 8; k++) e.d[k*IN_W +: IN_W] = row_val(kind, blk, k, c);
            exp_q.push_back(e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_rows(input int kind, input int blk, input int r0, input int r1,
                              input bit expect_ready);
        int guard;
        for (int r = r0; r <= r1; r++) begin
            in0 = row_val(kind, blk, r, 0);
            in1 = row_val(kind, blk, r, 1);
            in2 = row_val(kind, blk, r, 2);
            in3 = row_val(kind, blk, r, 3);
            in4 = row_val(kind, blk, r, 4);
            in5 = row_val(kind, blk, r, 5);
            in6 = row_val(kind, blk, r, 6);
            in7 = row_val(kind, blk, r, 7);
            in_valid = 1'b1;
            if (expect_ready) check_i("stream_in_ready", int'(in_ready), 1);
            guard = 0;
            while (!in_ready && guard < 500) begin
                tick(1);
                guard++;
            end
            if (!in_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL write_timeout: in_ready stayed 0, required 1 within 500 cycles");
            end
            tick(1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int guard = 0;
        while (exp_q.size() != 0 && guard < budget) begin
            tick(1);
            guard++;
        end
        check_i("drain_left", exp_q.size(), 0);
    endtask

    // Monitor: pops and compares on every accepted column, checks hold
    // stability under backpressure and zeroed outputs while idle.
    vec_t       cur;
    vec_t       held;
    logic [3:0] held_col;
    bit         hold_v = 1'b0;
    bit         chk_cont = 1'b0;
    bit         cont_started = 1'b0;
    int         cont_cnt = 0;
    col_t       e_mon;

    assign cur = {out7, out6, out5, out4, out3, out2, out1, out0};

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check_i("hold_valid", int'(out_valid), 1);
                check_v("hold_data", cur, held);
                check_i("hold_col", int'({out_last, out_col}), int'(held_col));
            end
            hold_v = 1'b0;
            if (chk_cont && cont_started && cont_cnt < 32)
                check_i("stream_cont", int'(out_valid), 1);
            if (!out_valid) begin
                check_v("idle_data", cur, '0);
                check_i("idle_col", int'({out_last, out_col}), 0);
            end else if (out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_column: got col %0d, required no output", out_col);
                end else begin
                    e_mon = exp_q.pop_front();
                    check_v("col_data", cur, e_mon.d);
                    check_i("col_idx", int'(out_col), int'(e_mon.col));
                    check_i("col_last", int'(out_last), int'(e_mon.col == 3'd7));
                end
                if (chk_cont) begin
                    cont_started = 1'b1;
                    cont_cnt++;
                end
            end else begin
                hold_v   = 1'b1;
                held     = cur;
                held_col = {out_last, out_col};
            end
        end
    end

    bit sent_done;

    initial begin
        // Reset state
        tick(3);
        rst = 1'b0;
        check_i("rst_in_ready", int'(in_ready), 1);
        check_i("rst_out_valid", int'(out_valid), 0);
        check_i("rst_col_last", int'({out_last, out_col}), 0);
        check_v("rst_data", cur, '0);

        // Single block with first-column latency
        out_ready = 1'b1;
        push_exp(0, 0);
        write_rows(0, 0, 0, 6, 1'b0);
        check_i("latency_pre", int'(out_valid), 0);
        write_rows(0, 0, 7, 7, 1'b0);
        check_i("latency_first", int'(out_valid), 1);
        wait_drain(100);

        // Back-to-back streaming of four blocks
        chk_cont = 1'b1;
        cont_started = 1'b0;
        cont_cnt = 0;
        for (int b = 0; b < 4; b++) push_exp(1, b);
        for (int b = 0; b < 4; b++) write_rows(1, b, 0, 7, 1'b1);
        wait_drain(100);
        check_i("stream_cols", cont_cnt, 32);
        chk_cont = 1'b0;

        // Backpressure: both banks fill, extra rows ignored
        out_ready = 1'b0;
        push_exp(1, 20);
        push_exp(1, 21);
        write_rows(1, 20, 0, 7, 1'b0);
        write_rows(1, 21, 0, 7, 1'b0);
        check_i("full_in_ready", int'(in_ready), 0);
        in0 = row_val(4, 0, 0, 0);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_i("full_stall", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            check_i("release_in_ready", int'(in_ready), int'(i == 8));
        end
        wait_drain(100);
        tick(2);
        check_i("no_ghost_block", int'(out_valid), 0);

        // Random backpressure with negative values
        sent_done = 1'b0;
        push_exp(2, 0);
        push_exp(2, 1);
        fork
            begin
                write_rows(2, 0, 0, 7, 1'b0);
                write_rows(2, 1, 0, 7, 1'b0);
                sent_done = 1'b1;
            end
            begin
                int guard = 0;
                while (!(sent_done && exp_q.size() == 0) && guard < 600) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick(1);
                    guard++;
                end
            end
        join
        out_ready = 1'b1;
        wait_drain(100);

        // Reset in the middle of a block
        write_rows(4, 0, 0, 4, 1'b0);
        rst = 1'b1;
        tick(1);
        check_i("midrst_out_valid", int'(out_valid), 0);
        check_v("midrst_data", cur, '0);
        check_i("midrst_in_ready", int'(in_ready), 1);
        tick(1);
        rst = 1'b0;
        tick(1);
        check_i("postrst_out_valid", int'(out_valid), 0);
        check_v("postrst_data", cur, '0);
        push_exp(3, 0);
        write_rows(3, 0, 0, 7, 1'b0);
        wait_drain(100);

        // Simultaneous write completion (bank 1) and read completion (bank 0)
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        out_ready = 1'b0;
        push_exp(1, 30);
        push_exp(1, 31);
        write_rows(1, 30, 0, 7, 1'b0);
        write_rows(1, 31, 0, 6, 1'b0);
        out_ready = 1'b1;
        tick(7);
        write_rows(1, 31, 7, 7, 1'b0);
        check_i("simul_out_valid", int'(out_valid), 1);
        check_i("simul_out_col", int'(out_col), 0);
        check_i("simul_in_ready", int'(in_ready), 1);
        check_v("simul_out0", vec_t'(out0), vec_t'(row_val(1, 31, 0, 0)));
        wait_drain(100);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
